hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across a dual common-anode display so that two 4-bit values show at once.
- Each cycle of operation alternates between digit 0 and digit 1, with a blanking gap between them to prevent ghosting.
- Sits between the switch/operand sources and the existing combinational segment decoder.
- Drives the decoder's 4-bit input and the two active-low anode enables (PNP transistor drivers).

Parameters:
REFRESH_CYCLES, 24000, clk cycles per digit slot (show time plus gap); 500 us at 48 MHz.
BLANK_CYCLES, 480, cycles at the end of each slot with both anodes off; 1 <= BLANK_CYCLES < REFRESH_CYCLES.

Ports:
clk  input  1  system clock (48 MHz HSOSC domain)
reset_n  input  1  asynchronous active-low reset
en  input  1  synchronous scan enable; low blanks the display
digit0  input  4  value for display 0; asynchronous, from switches
digit1  input  4  value for display 1; asynchronous, from switches
hex_sel  output  4  nibble to the shared segment decoder
an  output  2  anode enables, active-low; an[0] = display 0, an[1] = display 1
active_digit  output  1  0 while display 0 is lit or in its gap, 1 for display 1
frame_tick  output  1  one-cycle pulse on the first cycle of every SHOW0

Behaviour:
- Reset (reset_n low, asynchronous), all registers cleared:
  - state = OFF, counter = 0, snap0 = snap1 = 0, synchronizer flops = 0.
  - Outputs: an = 2'b11, hex_sel = 0, active_digit = 0, frame_tick = 0.
- Input synchronization:
  - digit0 and digit1 each pass through a 2-flop synchronizer, giving sync0 and sync1.
  - en is already synchronous and is not synchronized.
- Snapshot registers:
  - snap0 loads sync0 on the edge that enters SHOW0; snap1 loads sync1 on the edge that enters SHOW1.
  - The displayed nibble is therefore constant for a whole slot.
- Counter:
  - Width is clog2(REFRESH_CYCLES).
  - Cleared on every state transition; otherwise increments by 1 per cycle; never wraps inside a state.
- State machine (Moore; all outputs are registered or decoded from registered state):
  - OFF: an = 11, hex_sel = 0. If en = 1, go to SHOW0 on the next edge.
  - SHOW0: an = 10, hex_sel = snap0, active_digit = 0. Lasts REFRESH_CYCLES − BLANK_CYCLES cycles, then GAP0.
  - GAP0: an = 11, hex_sel holds snap0, active_digit = 0. Lasts BLANK_CYCLES cycles, then SHOW1.
  - SHOW1: an = 01, hex_sel = snap1, active_digit = 1. Lasts REFRESH_CYCLES − BLANK_CYCLES cycles, then GAP1.
  - GAP1: an = 11, hex_sel holds snap1, active_digit = 1. Lasts BLANK_CYCLES cycles, then SHOW0.
- frame_tick: high exactly in the first cycle of SHOW0, whether entered from OFF or from GAP1.
- an never equals 2'b00 in any cycle, including cycles adjacent to transitions.
- en deasserted in any state: OFF on the next edge, counter cleared, an = 11 from that cycle. en has priority over timeout transitions in the same cycle.
- en re-asserted: restart at SHOW0. There is no resume into SHOW1.
- Input-to-display latency:
  - A change on digitN reaches syncN after 2 edges.
  - It becomes visible at the next entry into SHOWN, so worst case is 2 + 2·REFRESH_CYCLES cycles.
  - A change during a SHOW slot does not alter hex_sel until that digit's next slot.
- Period: full frame = 2·REFRESH_CYCLES cycles; each display's duty = (REFRESH_CYCLES − BLANK_CYCLES) / (2·REFRESH_CYCLES).
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
Run the bench with REFRESH_CYCLES = 8 and BLANK_CYCLES = 2.
1. Reset and enable: hold reset_n = 0 with en = 1 and digits = 4'hA / 4'h3, then release.
   - Required: an = 11 during reset; SHOW0 entered the next edge.
   - Required: an = 10, hex_sel = A for 6 cycles; an = 11 for 2; an = 01, hex_sel = 3 for 6; an = 11 for 2; repeat.
   - Required: frame_tick pulses every 16 cycles.
2. Snapshot stability: change digit0 from 4'h5 to 4'hC at cycle 2 of SHOW0.
   - Required: hex_sel stays 5 for the rest of that slot; the next SHOW0 shows C.
3. Enable drop: drive en = 0 in cycle 3 of SHOW1.
   - Required: an = 11 and hex_sel = 0 the next cycle, held while en = 0.
   - Required: on en = 1, SHOW0 starts the following cycle with frame_tick = 1.
4. Priority: drive en = 0 coincident with the last cycle of GAP1.
   - Required: next state is OFF, not SHOW0; no frame_tick.
5. Asynchronous reset mid-SHOW0: pulse reset_n low between clock edges.
   - Required: an = 11, hex_sel = 0 and active_digit = 0 immediately; the sequence restarts cleanly afterwards.
6. Invariant and sweep:
   - Assertion: an != 2'b00 in every cycle.
   - Sweep all 16 values on both digits; hex_sel matches the respective snapshot in every SHOW cycle.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Scans two synchronized nibbles onto one shared segment decoder with blanked gaps between digits.
// Latency: digit input reaches the display at that digit's next slot (2 sync edges + up to 2*REFRESH_CYCLES).
// No backpressure: free-running scan; en low forces the display dark on the next edge.
module hex_display_scanner #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [3:0] hex_sel,
  output logic [1:0] an,
  output logic       active_digit,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_CYCLES - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SHOW0,
    ST_GAP0,
    ST_SHOW1,
    ST_GAP1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    meta0, meta1, sync0, sync1;
  logic [3:0]    snap0, snap1;

  // Switch inputs are asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta0 <= '0;
      meta1 <= '0;
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      meta0 <= digit0;
      meta1 <= digit1;
      sync0 <= meta0;
      sync1 <= meta1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   state_nxt = ST_SHOW0;
      ST_SHOW0: if (cnt == SHOW_LAST) state_nxt = ST_GAP0;
      ST_GAP0:  if (cnt == GAP_LAST)  state_nxt = ST_SHOW1;
      ST_SHOW1: if (cnt == SHOW_LAST) state_nxt = ST_GAP1;
      ST_GAP1:  if (cnt == GAP_LAST)  state_nxt = ST_SHOW0;
      default:  state_nxt = ST_OFF;
    endcase
    // Dropping en overrides any slot timeout in the same cycle.
    if (!en) state_nxt = ST_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
      cnt   <= '0;
      snap0 <= '0;
      snap1 <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state_nxt == ST_OFF) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;
      if (state_nxt == ST_SHOW0 && state != ST_SHOW0) snap0 <= sync0;
      if (state_nxt == ST_SHOW1 && state != ST_SHOW1) snap1 <= sync1;
    end
  end

  // Outputs decode only registered state, so an can never glitch to 00.
  always_comb begin
    an           = 2'b11;
    hex_sel      = 4'h0;
    active_digit = 1'b0;
    frame_tick   = 1'b0;
    case (state)
      ST_SHOW0: begin
        an         = 2'b10;
        hex_sel    = snap0;
        frame_tick = (cnt == '0);
      end
      ST_GAP0: hex_sel = snap0;
      ST_SHOW1: begin
        an           = 2'b01;
        hex_sel      = snap1;
        active_digit = 1'b1;
      end
      ST_GAP1: begin
        hex_sel      = snap1;
        active_digit = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner at REFRESH_CYCLES=8, BLANK_CYCLES=2.
// Observed word per cycle is {frame_tick, active_digit, an, hex_sel}.
module tb_hex_display_scanner;

  localparam int REF  = 8;
  localparam int BLK  = 2;
  localparam int SHOW = REF - BLK;
  localparam logic [7:0] OFF_VEC = {1'b0, 1'b0, 2'b11, 4'h0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit0 = 4'h0;
  logic [3:0] digit1 = 4'h0;
  logic [3:0] hex_sel;
  logic [1:0] an;
  logic       active_digit;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int ph    = 0;
  bit mon_on = 1'b0;

  hex_display_scanner #(.REFRESH_CYCLES(REF), .BLANK_CYCLES(BLK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .digit0       (digit0),
    .digit1       (digit1),
    .hex_sel      (hex_sel),
    .an           (an),
    .active_digit (active_digit),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {frame_tick, active_digit, an, hex_sel};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word for a phase within the 2*REF frame.
  function automatic logic [7:0] exp_vec(input int p, input logic [3:0] s0, input logic [3:0] s1);
    if (p < SHOW)            return {(p == 0), 1'b0, 2'b10, s0};
    else if (p < REF)        return {1'b0, 1'b0, 2'b11, s0};
    else if (p < REF + SHOW) return {1'b0, 1'b1, 2'b01, s1};
    else                     return {1'b0, 1'b1, 2'b11, s1};
  endfunction

  task automatic run(input string tag, input int n, input logic [3:0] s0, input logic [3:0] s1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, obs, exp_vec(ph, s0, s1));
      ph = (ph + 1) % (2 * REF);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, obs, OFF_VEC);
    end
  endtask

  always @(negedge clk)
    if (mon_on) chk("an_not_00", {7'b0, an == 2'b00}, 8'h00);

  initial begin
    logic [3:0] prev0;
    logic [3:0] v;

    // 1: reset with en high, then free-running scan
    en = 1'b1; digit0 = 4'hA; digit1 = 4'h3;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_in_reset", obs, OFF_VEC);
    reset_n = 1'b1;
    ph = 0;
    // First SHOW0 snapshots sync0 while the synchronizer still holds its reset value.
    run("t1_frame0", 16, 4'h0, 4'h3);
    run("t1_frames", 32, 4'hA, 4'h3);

    // 2: digit0 changes mid-slot; only the next slot shows it
    digit0 = 4'h5;
    run("t2_pre", 16, 4'hA, 4'h3);
    run("t2_show", 2, 4'h5, 4'h3);
    digit0 = 4'hC;
    run("t2_hold", 14, 4'h5, 4'h3);
    run("t2_next", 16, 4'hC, 4'h3);

    // 3: en drop in cycle 3 of SHOW1, then restart at SHOW0
    run("t3_pre", 12, 4'hC, 4'h3);
    en = 1'b0;
    idle("t3_off", 4);
    en = 1'b1;
    ph = 0;
    run("t3_restart", 16, 4'hC, 4'h3);

    // 4: en drop on the last GAP1 cycle wins over the timeout
    run("t4_pre", 16, 4'hC, 4'h3);
    en = 1'b0;
    idle("t4_off", 2);
    en = 1'b1;
    ph = 0;
    run("t4_restart", 16, 4'hC, 4'h3);

    // 5: asynchronous reset between edges inside SHOW0
    run("t5_pre", 3, 4'hC, 4'h3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_async", obs, OFF_VEC);
    idle("t5_hold", 2);
    reset_n = 1'b1;
    ph = 0;
    run("t5_frame0", 16, 4'h0, 4'h3);
    run("t5_frame1", 16, 4'hC, 4'h3);

    // 6: sweep all nibbles; new digit0 lands next frame, new digit1 this frame
    prev0 = 4'hC;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      digit0 = v;
      digit1 = ~v;
      run("t6_sweep", 16, prev0, ~v);
      prev0 = v;
    end
    run("t6_tail", 8, prev0, 4'h0);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
